// File: rtl/idex_pipe.sv
// ID/EX pipeline register: captures decoded fields and register-file operands,
// bypasses same-cycle writeback, inserts load-use bubbles, honours stall/flush.
module idex_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            id_rd,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_is_load,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic [DATA_WIDTH-1:0] r1,
  input  logic [DATA_WIDTH-1:0] r2,
  input  logic                  wb_wr_en,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  ex_stall,
  input  logic                  flush,
  output logic                  id_stall,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [4:0]            ex_rs1,
  output logic [4:0]            ex_rs2,
  output logic [4:0]            ex_rd,
  output logic                  ex_is_load,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [DATA_WIDTH-1:0] ex_op1,
  output logic [DATA_WIDTH-1:0] ex_op2
);

  logic                  ex_valid_reg;
  logic [DATA_WIDTH-1:0] ex_pc_reg;
  logic [DATA_WIDTH-1:0] ex_imm_reg;
  logic [4:0]            ex_rs1_reg;
  logic [4:0]            ex_rs2_reg;
  logic [4:0]            ex_rd_reg;
  logic                  ex_is_load_reg;
  logic [CTRL_W-1:0]     ex_ctrl_reg;
  logic [DATA_WIDTH-1:0] ex_op1_reg;
  logic [DATA_WIDTH-1:0] ex_op2_reg;

  logic                  wb_live;
  logic [DATA_WIDTH-1:0] byp1;
  logic [DATA_WIDTH-1:0] byp2;
  logic                  hz;

  // The register file returns the old value during its write cycle, so
  // writeback data must be forwarded into the captured operands here.
  assign wb_live = wb_wr_en && (wb_rd != 5'd0);

  always_comb begin
    byp1 = r1;
    byp2 = r2;
    if (wb_live && (wb_rd == id_rs1)) byp1 = wb_data;
    if (wb_live && (wb_rd == id_rs2)) byp2 = wb_data;
  end

  always_comb begin
    hz = 1'b0;
    if (ex_valid_reg && ex_is_load_reg && (ex_rd_reg != 5'd0) && id_valid) begin
      hz = (id_use_rs1 && (id_rs1 == ex_rd_reg)) ||
           (id_use_rs2 && (id_rs2 == ex_rd_reg));
    end
  end

  assign id_stall = ex_stall || hz;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg   <= 1'b0;
      ex_pc_reg      <= '0;
      ex_imm_reg     <= '0;
      ex_rs1_reg     <= '0;
      ex_rs2_reg     <= '0;
      ex_rd_reg      <= '0;
      ex_is_load_reg <= 1'b0;
      ex_ctrl_reg    <= '0;
      ex_op1_reg     <= '0;
      ex_op2_reg     <= '0;
    end else if (flush) begin
      ex_valid_reg <= 1'b0;
    end else if (ex_stall) begin
      // Held operands keep tracking writebacks so they are current on release.
      if (ex_valid_reg && wb_live && (wb_rd == ex_rs1_reg)) ex_op1_reg <= wb_data;
      if (ex_valid_reg && wb_live && (wb_rd == ex_rs2_reg)) ex_op2_reg <= wb_data;
    end else if (hz) begin
      ex_valid_reg   <= 1'b0;
      ex_is_load_reg <= 1'b0;
      ex_ctrl_reg    <= '0;
    end else begin
      ex_valid_reg   <= id_valid;
      ex_pc_reg      <= id_pc;
      ex_imm_reg     <= id_imm;
      ex_rs1_reg     <= id_rs1;
      ex_rs2_reg     <= id_rs2;
      ex_rd_reg      <= id_rd;
      ex_is_load_reg <= id_is_load;
      ex_ctrl_reg    <= id_ctrl;
      ex_op1_reg     <= byp1;
      ex_op2_reg     <= byp2;
    end
  end

  assign ex_valid   = ex_valid_reg;
  assign ex_pc      = ex_pc_reg;
  assign ex_imm     = ex_imm_reg;
  assign ex_rs1     = ex_rs1_reg;
  assign ex_rs2     = ex_rs2_reg;
  assign ex_rd      = ex_rd_reg;
  assign ex_is_load = ex_is_load_reg;
  assign ex_ctrl    = ex_ctrl_reg;
  assign ex_op1     = ex_op1_reg;
  assign ex_op2     = ex_op2_reg;

endmodule

// File: tb/tb_idex_pipe.sv
// Scoreboard bench for idex_pipe: directed vectors push expected EX state,
// a monitor pops and compares after each clock edge.
module tb_idex_pipe;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [DW-1:0] id_pc, id_imm;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_is_load;
  logic [CW-1:0] id_ctrl;
  logic [DW-1:0] r1, r2;
  logic          wb_wr_en;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
  logic          ex_stall, flush;
  logic          id_stall, ex_valid, ex_is_load;
  logic [DW-1:0] ex_pc, ex_imm, ex_op1, ex_op2;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [CW-1:0] ex_ctrl;

  idex_pipe #(.DATA_WIDTH(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_is_load(id_is_load),
    .id_ctrl(id_ctrl), .r1(r1), .r2(r2),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_ctrl(ex_ctrl), .ex_op1(ex_op1), .ex_op2(ex_op2)
  );

  always #5 clk = ~clk;

  // chk bits: 0 valid, 1 pc, 2 op1, 3 op2, 4 rs2, 5 is_load, 6 ctrl
  typedef struct {
    string         name;
    logic [6:0]    chk;
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [4:0]    rs2;
    logic          ld;
    logic [CW-1:0] ctrl;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic cmp(input string name, input string field,
                     input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, field, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [6:0] chk, input logic v,
                      input logic [DW-1:0] pc, input logic [DW-1:0] op1,
                      input logic [DW-1:0] op2, input logic [4:0] rs2,
                      input logic ld, input logic [CW-1:0] ctrl);
    exp_t e;
    e.name = name; e.chk = chk; e.valid = v; e.pc = pc; e.op1 = op1;
    e.op2 = op2; e.rs2 = rs2; e.ld = ld; e.ctrl = ctrl;
    sb.push_back(e);
  endtask

  // Monitor: one expected EX snapshot per clock edge that has one queued.
  always begin
    @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.chk[0]) cmp(e.name, "ex_valid",   {31'd0, ex_valid},   {31'd0, e.valid});
      if (e.chk[1]) cmp(e.name, "ex_pc",      ex_pc,               e.pc);
      if (e.chk[2]) cmp(e.name, "ex_op1",     ex_op1,              e.op1);
      if (e.chk[3]) cmp(e.name, "ex_op2",     ex_op2,              e.op2);
      if (e.chk[4]) cmp(e.name, "ex_rs2",     {27'd0, ex_rs2},     {27'd0, e.rs2});
      if (e.chk[5]) cmp(e.name, "ex_is_load", {31'd0, ex_is_load}, {31'd0, e.ld});
      if (e.chk[6]) cmp(e.name, "ex_ctrl",    {16'd0, ex_ctrl},    {16'd0, e.ctrl});
      $display("vec %-14s ex_valid=%0d ex_pc=0x%0h ex_op1=0x%0h ex_op2=0x%0h",
               e.name, ex_valid, ex_pc, ex_op1, ex_op2);
    end
  end

  task automatic instr(input logic v, input logic [DW-1:0] pc,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic ld,
                       input logic [CW-1:0] ctrl, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2);
    id_valid = v; id_pc = pc; id_imm = pc + 32'h1000; id_rs1 = rs1; id_rs2 = rs2;
    id_rd = rd; id_use_rs1 = u1; id_use_rs2 = u2; id_is_load = ld; id_ctrl = ctrl;
    r1 = d1; r2 = d2;
  endtask

  task automatic wb(input logic en, input logic [4:0] rd, input logic [DW-1:0] d);
    wb_wr_en = en; wb_rd = rd; wb_data = d;
  endtask

  task automatic chk_stall(input string name, input logic exp);
    #1;
    cmp(name, "id_stall", {31'd0, id_stall}, {31'd0, exp});
  endtask

  localparam logic [6:0] ALL = 7'h7F;
  localparam logic [6:0] VLD = 7'h01;

  initial begin
    rst = 1'b1; ex_stall = 1'b0; flush = 1'b0;
    wb(0, 0, 0);
    instr(1, 32'h100, 5'd1, 5'd2, 5'd3, 1, 1, 0, 16'hAAAA, 32'h55, 32'h66);

    // Reset held two cycles with a valid instruction presented
    @(negedge clk);
    push("reset1", 7'h45, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    push("reset2", ALL, 0, 0, 0, 0, 0, 0, 0);
    chk_stall("reset2", 0);
    @(negedge clk);
    rst = 1'b0;
    push("first", ALL, 1, 32'h100, 32'h55, 32'h66, 5'd2, 0, 16'hAAAA);
    chk_stall("first", 0);

    // Writeback bypass into rs1; rs2 untouched
    @(negedge clk);
    instr(1, 32'h104, 5'd5, 5'd6, 5'd8, 1, 1, 0, 16'h0001, 32'h11, 32'h22);
    wb(1, 5'd5, 32'hAB);
    push("byp_rs1", 7'h0F, 1, 32'h104, 32'hAB, 32'h22, 0, 0, 0);
    // Write to x0 never bypasses
    @(negedge clk);
    instr(1, 32'h108, 5'd0, 5'd0, 5'd8, 1, 1, 0, 16'h0002, 32'h0, 32'h0);
    wb(1, 5'd0, 32'hCD);
    push("byp_x0", 7'h0F, 1, 32'h108, 32'h0, 32'h0, 0, 0, 0);
    // Write enable low: no bypass
    @(negedge clk);
    instr(1, 32'h10C, 5'd5, 5'd5, 5'd8, 1, 1, 0, 16'h0003, 32'h11, 32'h11);
    wb(0, 5'd5, 32'hAB);
    push("byp_noen", 7'h0F, 1, 32'h10C, 32'h11, 32'h11, 0, 0, 0);

    // Load-use on rs2: one bubble, then dependent captures bypassed value
    @(negedge clk);
    instr(1, 32'h200, 5'd1, 5'd0, 5'd7, 1, 0, 1, 16'h00F0, 32'h1000, 32'h0);
    wb(0, 0, 0);
    push("ld", 7'h23, 1, 32'h200, 0, 0, 0, 1, 0);
    chk_stall("ld", 0);
    @(negedge clk);
    instr(1, 32'h204, 5'd2, 5'd7, 5'd9, 1, 1, 0, 16'h00F1, 32'h2, 32'h0);
    push("bubble", 7'h61, 0, 0, 0, 0, 0, 0, 16'h0);
    chk_stall("hz_on", 1);
    @(negedge clk);
    wb(1, 5'd7, 32'h77);
    push("dep", 7'h5B, 1, 32'h204, 32'h2, 32'h77, 5'd7, 0, 16'h00F1);
    chk_stall("hz_off", 0);
    // Same pair but rs2 not used: no stall
    @(negedge clk);
    wb(0, 0, 0);
    instr(1, 32'h300, 5'd1, 5'd0, 5'd7, 1, 0, 1, 16'h0, 32'h1, 32'h0);
    push("ld2", 7'h23, 1, 32'h300, 0, 0, 0, 1, 0);
    @(negedge clk);
    instr(1, 32'h304, 5'd2, 5'd7, 5'd9, 0, 0, 0, 16'h0, 32'h2, 32'h3);
    push("nouse", 7'h03, 1, 32'h304, 0, 0, 0, 0, 0);
    chk_stall("nouse", 0);
    // Load to x0 followed by a use of x0: no stall
    @(negedge clk);
    instr(1, 32'h308, 5'd1, 5'd0, 5'd0, 1, 0, 1, 16'h0, 32'h1, 32'h0);
    push("ld_x0", 7'h03, 1, 32'h308, 0, 0, 0, 0, 0);
    @(negedge clk);
    instr(1, 32'h30C, 5'd0, 5'd0, 5'd9, 1, 1, 0, 16'h0, 32'h0, 32'h0);
    push("use_x0", 7'h03, 1, 32'h30C, 0, 0, 0, 0, 0);
    chk_stall("use_x0", 0);

    // EX stall for 3 cycles with a writeback to x3 in the second
    @(negedge clk);
    instr(1, 32'h400, 5'd3, 5'd4, 5'd10, 1, 1, 0, 16'h1234, 32'h5, 32'h6);
    push("stl_load", ALL, 1, 32'h400, 32'h5, 32'h6, 5'd4, 0, 16'h1234);
    @(negedge clk);
    ex_stall = 1'b1;
    instr(1, 32'h404, 5'd11, 5'd12, 5'd13, 1, 1, 0, 16'h5678, 32'h7, 32'h8);
    push("stl1", ALL, 1, 32'h400, 32'h5, 32'h6, 5'd4, 0, 16'h1234);
    chk_stall("stl1", 1);
    @(negedge clk);
    wb(1, 5'd3, 32'h99);
    push("stl2", ALL, 1, 32'h400, 32'h99, 32'h6, 5'd4, 0, 16'h1234);
    chk_stall("stl2", 1);
    @(negedge clk);
    wb(0, 0, 0);
    push("stl3", ALL, 1, 32'h400, 32'h99, 32'h6, 5'd4, 0, 16'h1234);
    chk_stall("stl3", 1);
    @(negedge clk);
    ex_stall = 1'b0;
    push("stl_rel", ALL, 1, 32'h404, 32'h7, 32'h8, 5'd12, 0, 16'h5678);
    chk_stall("stl_rel", 0);

    // Flush beats simultaneous ex_stall and load-use hazard
    @(negedge clk);
    instr(1, 32'h500, 5'd1, 5'd0, 5'd7, 1, 0, 1, 16'h0, 32'h1, 32'h0);
    push("fl_ld", 7'h23, 1, 32'h500, 0, 0, 0, 1, 0);
    @(negedge clk);
    instr(1, 32'h504, 5'd7, 5'd0, 5'd9, 1, 0, 0, 16'h0, 32'h0, 32'h0);
    ex_stall = 1'b1; flush = 1'b1;
    push("fl_prio", VLD, 0, 0, 0, 0, 0, 0, 0);
    chk_stall("fl_prio", 1);
    @(negedge clk);
    ex_stall = 1'b0; flush = 1'b1;
    instr(1, 32'h508, 5'd1, 5'd2, 5'd9, 1, 1, 0, 16'h0, 32'h0, 32'h0);
    push("fl_plain", VLD, 0, 0, 0, 0, 0, 0, 0);
    chk_stall("fl_plain", 0);
    @(negedge clk);
    flush = 1'b0;
    instr(0, 32'h50C, 5'd1, 5'd2, 5'd9, 1, 1, 0, 16'h0, 32'h0, 32'h0);
    push("inval", VLD, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back independent instructions
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      instr(1, 32'(i * 4), 5'd1, 5'd2, 5'd3, 1, 1, 0, 16'(i), 32'(i + 16), 32'h0);
      push($sformatf("b2b%0d", i), 7'h47, 1, 32'(i * 4), 32'(i + 16), 0, 0, 0, 16'(i));
    end
    @(negedge clk);
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/idex_pipe.md
Name: idex_pipe

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the register file.
- Captures decoded fields and the two register-file read operands, and bypasses same-cycle writeback data into them. The register file writes synchronously, so a read in the write cycle returns the old value.
- Detects load-use hazards and inserts bubbles. Honours downstream stall and branch flush.
- Feeds the execute stage.

Parameters:
- DATA_WIDTH, 32, operand/PC/immediate width.
- CTRL_W, 16, width of opaque decoded control bundle passed through to EX.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_pc  in  DATA_WIDTH  instruction PC.
- id_imm  in  DATA_WIDTH  decoded immediate.
- id_rs1, id_rs2, id_rd  in  5  register indices; rs1/rs2 also drive register-file read addresses.
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2.
- id_is_load  in  1  instruction is a load.
- id_ctrl  in  CTRL_W  decoded control bundle.
- r1, r2  in  DATA_WIDTH  register-file read data for id_rs1/id_rs2; x0 reads as 0.
- wb_wr_en  in  1  writeback write enable, same signal as the register-file write enable.
- wb_rd  in  5  writeback destination.
- wb_data  in  DATA_WIDTH  writeback data.
- ex_stall  in  1  EX cannot accept; hold EX register.
- flush  in  1  branch/jump redirect; kill ID and EX contents.
- id_stall  out  1  hold PC and IF/ID (combinational).
- ex_valid  out  1  EX register holds valid instruction.
- ex_pc, ex_imm  out  DATA_WIDTH  registered copies.
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices.
- ex_is_load  out  1  registered.
- ex_ctrl  out  CTRL_W  registered.
- ex_op1, ex_op2  out  DATA_WIDTH  registered operands after bypass.

Behaviour:
- Reset:
  - ex_valid=0, ex_is_load=0, ex_ctrl=0.
  - All data/index outputs are 0.
  - id_stall follows its equation; it is 0 once state is reset and ex_stall=0.
- Bypass (combinational, on ID side):
  - byp1 = (wb_wr_en && wb_rd!=0 && wb_rd==id_rs1) ? wb_data : r1.
  - byp2 is the same using id_rs2/r2.
  - Writes to x0 never bypass.
- Load-use hazard:
  - hz = ex_valid && ex_is_load && ex_rd!=0 && id_valid && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
- id_stall = ex_stall || hz.
  - Flush does not raise id_stall; the upstream stage handles its own flush.
- Posedge update priority:
  1. rst: reset values.
  2. flush: ex_valid<=0; other fields don't-care (hold). Overrides ex_stall and hz.
  3. ex_stall: hold all EX fields. Exception: if ex_valid && wb_wr_en && wb_rd!=0 && wb_rd==ex_rs1, then ex_op1<=wb_data; likewise wb_rd==ex_rs2 updates ex_op2. This keeps held operands fresh.
  4. hz: bubble; ex_valid<=0, ex_is_load<=0, ex_ctrl<=0. The ID instruction stays in ID, since id_stall=1.
  5. Otherwise: ex_valid<=id_valid; capture all id_* fields; ex_op1<=byp1, ex_op2<=byp2.
- Latency: 1 cycle ID->EX. A load-use pair costs exactly 1 bubble. After the bubble, the dependent instruction captures via byp* or r* normally.
- Invalid ID (id_valid=0): hz=0. Fields may still be captured, but ex_valid=0.
- No combinational path from ex_stall/flush to ex_* outputs. The only combinational output is id_stall.

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 -> ex_valid=0, ex_op1=0, ex_ctrl=0; after release, first id instr (pc=0x100) appears on ex_pc one cycle later.
- Writeback bypass: x5 holds 0x11 in register file, id_rs1=5 while wb_wr_en=1, wb_rd=5, wb_data=0xAB -> next cycle ex_op1=0xAB. Repeat with wb_rd=0 and id_rs1=0 -> ex_op1=0.
- Load-use: EX holds load with ex_rd=7; ID instr rs2=7, use_rs2=1 -> id_stall=1 for exactly 1 cycle, ex_valid=0 next cycle, then dependent instr enters EX with ex_rs2=7. Same case with use_rs2=0 -> no stall.
- EX stall with refresh: ex_valid=1, ex_rs1=3, ex_op1=0x5; hold ex_stall=1 for 3 cycles, WB writes x3=0x99 in 2nd cycle -> ex_op1=0x99, other fields unchanged, id_stall=1 throughout.
- Flush priority: flush=1 with ex_stall=1 and hz=1 simultaneously -> ex_valid=0 next cycle; flush with id_valid=1 and no stall -> ex_valid=0.
- Back-to-back: 4 independent valid instructions, pc 0x0/0x4/0x8/0xC, no stalls -> ex_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles, ex_valid continuously 1.
